// File: rtl/prbs_pkg.sv
// Shared definitions for the 7-bit x^7+x^6+1 sequence: width, taps,
// checker state encoding and the generator's reset seed.
package prbs_pkg;

  localparam int PRBS7_W = 7;
  localparam int TAP_HI  = 6;
  localparam int TAP_LO  = 5;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [PRBS7_W-1:0] GEN_SEED = 7'h0F;

endpackage

// File: rtl/prbs7_step.sv
// One step of the x^7+x^6+1 sequence: feedback bit and advanced state.
module prbs7_step
  import prbs_pkg::*;
(
  input  logic [PRBS7_W-1:0] s,
  output logic               fb,
  output logic [PRBS7_W-1:0] s_next
);

  assign fb     = s[TAP_HI] ^ s[TAP_LO];
  assign s_next = {s[PRBS7_W-2:0], fb};

endmodule

// File: rtl/prbs7_checker.sv
// Self-seeding PRBS7 receiver check: locks onto the incoming stream, then
// free-runs its own prediction and counts mismatches, dropping lock on bursts.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_errors,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 sync_loss
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  state_t               state, state_nx;
  logic [PRBS7_W-1:0]   s, s_nx, s_pred, seed_word;
  logic [2:0]           seed_cnt, seed_cnt_nx;
  logic [WIN_W-1:0]     win_cnt, win_cnt_nx;
  logic [WERR_W-1:0]    win_err, win_err_nx, win_err_inc;
  logic [ERR_CNT_W-1:0] error_count_nx;
  logic                 error_pulse_nx, sync_loss_nx;
  logic                 pred, mismatch, lose;

  prbs7_step u_step (
    .s      (s),
    .fb     (pred),
    .s_next (s_pred)
  );

  assign seed_word   = {s[PRBS7_W-2:0], bit_in};
  assign win_err_inc = win_err + WERR_W'(1);
  assign mismatch    = bit_valid && (state == CHECK) && (bit_in != pred);
  // A window's last bit still sees that window's errors before they clear.
  assign lose        = mismatch && (win_err_inc >= WERR_W'(LOSS_THRESH));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SEED;
      s           <= '0;
      seed_cnt    <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      error_count <= '0;
      error_pulse <= 1'b0;
      sync_loss   <= 1'b0;
    end else begin
      state       <= state_nx;
      s           <= s_nx;
      seed_cnt    <= seed_cnt_nx;
      win_cnt     <= win_cnt_nx;
      win_err     <= win_err_nx;
      error_count <= error_count_nx;
      error_pulse <= error_pulse_nx;
      sync_loss   <= sync_loss_nx;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    s_nx        = s;
    seed_cnt_nx = seed_cnt;
    win_cnt_nx  = win_cnt;
    win_err_nx  = win_err;
    if (bit_valid) begin
      unique case (state)
        SEED: begin
          s_nx = seed_word;
          if (seed_cnt == 3'd6) begin
            seed_cnt_nx = '0;
            win_cnt_nx  = '0;
            win_err_nx  = '0;
            if (seed_word != '0) state_nx = CHECK;
          end else begin
            seed_cnt_nx = seed_cnt + 3'd1;
          end
        end
        CHECK: begin
          // Free-run on the prediction so a flipped bit costs one error only.
          s_nx = s_pred;
          if (lose) begin
            state_nx    = SEED;
            seed_cnt_nx = '0;
            win_cnt_nx  = '0;
            win_err_nx  = '0;
          end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt_nx = '0;
            win_err_nx = '0;
          end else begin
            win_cnt_nx = win_cnt + WIN_W'(1);
            if (mismatch) win_err_nx = win_err_inc;
          end
        end
        default: state_nx = SEED;
      endcase
    end
  end

  always_comb begin
    locked         = (state == CHECK);
    error_pulse_nx = mismatch;
    sync_loss_nx   = lose;
    error_count_nx = clear_errors ? '0 : error_count;
    if (mismatch && (error_count_nx != '1))
      error_count_nx = error_count_nx + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: directed scenarios plus random traffic, compared
// cycle by cycle against a bit-queue model of the received sequence.
module tb_prbs7_checker;
  import prbs_pkg::*;

  localparam int ERR_W   = 16;
  localparam int WIN     = 64;
  localparam int THR     = 4;
  localparam int CNT_MAX = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             bit_in, bit_valid, clear_errors;
  logic             locked, error_pulse, sync_loss;
  logic [ERR_W-1:0] error_count;
  logic             sat_locked, sat_pulse, sat_loss;
  logic [3:0]       sat_count;

  always #5 clock = ~clock;

  prbs7_checker #(.ERR_CNT_W(ERR_W), .WINDOW(WIN), .LOSS_THRESH(THR)) dut (
    .clock        (clock),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .clear_errors (clear_errors),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .error_count  (error_count),
    .sync_loss    (sync_loss)
  );

  prbs7_checker #(.ERR_CNT_W(4), .WINDOW(64), .LOSS_THRESH(64)) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .clear_errors (clear_errors),
    .locked       (sat_locked),
    .error_pulse  (sat_pulse),
    .error_count  (sat_count),
    .sync_loss    (sat_loss)
  );

  int checks   = 0;
  int failures = 0;
  int pulses_seen, losses_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: received bits as a queue; locked prediction follows
  // b[n] = b[n-7] ^ b[n-6] over the last seven predicted bits.
  bit m_locked, m_pulse, m_loss;
  bit seed_q[$];
  bit hist[$];
  int win_idx, win_errs, m_cnt;

  function automatic void model_reset();
    m_locked = 0; m_pulse = 0; m_loss = 0;
    seed_q.delete(); hist.delete();
    win_idx = 0; win_errs = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit clr);
    bit pred, any;
    m_pulse = 0;
    m_loss  = 0;
    if (clr) m_cnt = 0;
    if (!v) return;
    if (!m_locked) begin
      seed_q.push_back(b);
      if (seed_q.size() == 7) begin
        any = 0;
        foreach (seed_q[i]) any |= seed_q[i];
        if (any) begin
          m_locked = 1;
          hist     = seed_q;
          win_idx  = 0;
          win_errs = 0;
        end
        seed_q.delete();
      end
    end else begin
      pred = hist[0] ^ hist[1];
      void'(hist.pop_front());
      hist.push_back(pred);
      if (b != pred) begin
        m_pulse = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        win_errs++;
      end
      if (win_errs >= THR) begin
        m_loss   = 1;
        m_locked = 0;
      end
      win_idx++;
      if (win_idx == WIN) begin
        win_idx  = 0;
        win_errs = 0;
      end
    end
  endfunction

  // Stimulus generator: the transmitting x^7+x^6+1 source.
  logic [6:0] g;
  function automatic logic gen_bit();
    logic fb;
    fb = g[6] ^ g[5];
    g  = {g[5:0], fb};
    return fb;
  endfunction

  task automatic drive(input logic b, input logic v, input logic clr);
    bit_in       = b;
    bit_valid    = v;
    clear_errors = clr;
    @(posedge clock);
    model_step(b, v, clr);
    #1;
    check("locked", locked, m_locked);
    check("error_pulse", error_pulse, m_pulse);
    check("sync_loss", sync_loss, m_loss);
    check("error_count", error_count, m_cnt);
    pulses_seen += int'(error_pulse);
    losses_seen += int'(sync_loss);
  endtask

  task automatic send_masked(input int n, input logic [255:0] mask);
    for (int i = 0; i < n; i++) drive(gen_bit() ^ mask[i], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_errors = 1'b0;
    g = GEN_SEED;
    model_reset();
    pulses_seen = 0; losses_seen = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", error_pulse, 0);
    check("rst_sync_loss", sync_loss, 0);
    check("rst_count", error_count, 0);
    check("rst_sat_count", sat_count, 0);
    @(negedge clock) reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] mask;
    int nv;
    logic v, b;

    // Lock from reset and a long clean run.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(gen_bit(), 1'b1, 1'b0);
      if (i == 5) check("pre_lock", locked, 0);
    end
    check("lock_latency", locked, 1);
    send_masked(254, '0);
    check("clean_count", error_count, 0);
    check("clean_pulses", pulses_seen, 0);
    check("clean_losses", losses_seen, 0);

    // Single flipped bit at checked index 20.
    do_reset();
    send_masked(7, '0);
    mask = '0; mask[20] = 1'b1;
    send_masked(80, mask);
    check("single_pulses", pulses_seen, 1);
    check("single_count", error_count, 1);
    check("single_locked", locked, 1);

    // Four errors in one window drop lock; clean bits relock after seven.
    do_reset();
    send_masked(7, '0);
    mask = '0; mask[2] = 1'b1; mask[5] = 1'b1; mask[9] = 1'b1; mask[13] = 1'b1;
    send_masked(14, mask);
    check("loss_pulses", losses_seen, 1);
    check("loss_locked", locked, 0);
    check("loss_count", error_count, 4);
    send_masked(7, '0);
    check("relock", locked, 1);
    send_masked(40, '0);
    check("relock_count", error_count, 4);
    check("relock_losses", losses_seen, 1);

    // Three errors either side of the window boundary: no loss.
    do_reset();
    send_masked(7, '0);
    mask = '0;
    mask[60] = 1'b1; mask[61] = 1'b1; mask[62] = 1'b1;
    mask[64] = 1'b1; mask[65] = 1'b1; mask[66] = 1'b1;
    send_masked(100, mask);
    check("win_losses", losses_seen, 0);
    check("win_count", error_count, 6);
    check("win_locked", locked, 1);

    // All-zero seed is rejected, then a gappy stream locks cleanly.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
    check("zero_seed_locked", locked, 0);
    nv = 0;
    for (int i = 0; i < 1000 && nv < 127; i++) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) begin
        drive(gen_bit(), 1'b1, 1'b0);
        nv++;
      end else begin
        drive(1'($urandom), 1'b0, 1'b0);
      end
    end
    check("gap_valid_bits", nv, 127);
    check("gap_locked", locked, 1);
    check("gap_count", error_count, 0);

    // clear_errors coincident with an error leaves a count of one.
    do_reset();
    send_masked(7, '0);
    mask = '0; mask[3] = 1'b1; mask[10] = 1'b1;
    send_masked(15, mask);
    check("pre_clear_count", error_count, 2);
    drive(~gen_bit(), 1'b1, 1'b1);
    check("clear_with_error", error_count, 1);
    check("clear_locked", locked, 1);
    drive(gen_bit(), 1'b0, 1'b1);
    check("clear_on_idle", error_count, 0);

    // Saturation on the 4-bit instance with an inverted stream.
    do_reset();
    send_masked(7, '0);
    send_masked(20, '1);
    check("sat_count", sat_count, 15);
    check("sat_locked", sat_locked, 1);
    check("sat_losses", sat_loss, 0);

    // Random traffic: gaps, sparse flips and clears.
    do_reset();
    send_masked(7, '0);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = v ? (gen_bit() ^ ($urandom_range(0, 29) == 0)) : 1'($urandom);
      drive(b, v, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset in the middle of a locked cycle.
    do_reset();
    send_masked(7, '0);
    mask = '0; mask[2] = 1'b1;
    send_masked(3, mask);
    check("pre_areset_count", error_count, 1);
    check("pre_areset_pulse", error_pulse, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("areset_locked", locked, 0);
    check("areset_pulse", error_pulse, 0);
    check("areset_sync_loss", sync_loss, 0);
    check("areset_count", error_count, 0);
    @(negedge clock) reset = 1'b0;
    send_masked(6, '0);
    check("fresh_seed_unlocked", locked, 0);
    send_masked(1, '0);
    check("fresh_seed_locked", locked, 1);
    send_masked(30, '0);
    check("fresh_seed_count", error_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
